// File: rtl/xbar_pipe.sv
// rtl/xbar_pipe.sv - pipelined multi-mode lane crossbar
// Combinational routing (rotate/direct scatter, gather, broadcast) feeding a LATENCY-deep stall-as-one pipeline.
module xbar_pipe #(
  parameter int SIZE    = 32,
  parameter int DWIDTH  = 16,
  parameter int LATENCY = 2,
  parameter int IDXW    = $clog2(SIZE)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               mode_i,
  input  logic [SIZE*DWIDTH-1:0]   in_data_i,
  input  logic [SIZE*IDXW-1:0]     in_idx_i,
  input  logic [SIZE-1:0]          in_mask_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [SIZE*DWIDTH-1:0]   out_data_o,
  output logic [SIZE-1:0]          out_mask_o,
  output logic                     out_conflict_o
);

  logic [SIZE*DWIDTH-1:0] route_data_d;
  logic [SIZE-1:0]        route_mask_d;
  logic                   route_conflict_d;
  logic [IDXW-1:0]        dest;
  logic [IDXW-1:0]        src;

  always_comb begin
    route_data_d     = '0;
    route_mask_d     = '0;
    route_conflict_d = 1'b0;
    dest             = '0;
    src              = '0;
    case (mode_i)
      2'b00, 2'b01: begin
        // Ascending lane order makes the lowest enabled source win each destination.
        for (int i = 0; i < SIZE; i++) begin
          if (in_mask_i[i]) begin
            if (mode_i == 2'b00) dest = IDXW'(i) + in_idx_i[i*IDXW +: IDXW];
            else                 dest = in_idx_i[i*IDXW +: IDXW];
            if (route_mask_d[dest]) begin
              route_conflict_d = 1'b1;
            end else begin
              route_mask_d[dest]                  = 1'b1;
              route_data_d[dest*DWIDTH +: DWIDTH] = in_data_i[i*DWIDTH +: DWIDTH];
            end
          end
        end
      end
      2'b10: begin
        for (int j = 0; j < SIZE; j++) begin
          src = in_idx_i[j*IDXW +: IDXW];
          if (in_mask_i[j] && in_mask_i[src]) begin
            route_mask_d[j]                  = 1'b1;
            route_data_d[j*DWIDTH +: DWIDTH] = in_data_i[src*DWIDTH +: DWIDTH];
          end
        end
      end
      default: begin
        src = in_idx_i[0 +: IDXW];
        for (int j = 0; j < SIZE; j++) begin
          if (in_mask_i[j] && in_mask_i[src]) begin
            route_mask_d[j]                  = 1'b1;
            route_data_d[j*DWIDTH +: DWIDTH] = in_data_i[src*DWIDTH +: DWIDTH];
          end
        end
      end
    endcase
  end

  logic [LATENCY-1:0]     valid_q;
  logic [LATENCY-1:0]     conflict_q;
  logic [SIZE*DWIDTH-1:0] data_q [LATENCY];
  logic [SIZE-1:0]        mask_q [LATENCY];
  logic                   advance;
  logic                   accept;

  // Whole pipe stalls together; bubbles are carried rather than collapsed.
  assign advance    = !valid_q[LATENCY-1] || out_ready_i;
  assign in_ready_o = advance && !rst_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      conflict_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= '0;
        mask_q[s] <= '0;
      end
    end else if (advance) begin
      valid_q[0]    <= accept;
      conflict_q[0] <= accept ? route_conflict_d : 1'b0;
      data_q[0]     <= accept ? route_data_d : '0;
      mask_q[0]     <= accept ? route_mask_d : '0;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s]    <= valid_q[s-1];
        conflict_q[s] <= conflict_q[s-1];
        data_q[s]     <= data_q[s-1];
        mask_q[s]     <= mask_q[s-1];
      end
    end
  end

  assign out_valid_o    = valid_q[LATENCY-1];
  assign out_conflict_o = conflict_q[LATENCY-1];
  assign out_data_o     = data_q[LATENCY-1];
  assign out_mask_o     = mask_q[LATENCY-1];

endmodule

// File: tb/tb_xbar_pipe.sv
// tb/tb_xbar_pipe.sv - directed self-checking bench for xbar_pipe
// Linear directed steps; each comparison is an immediate assertion.
module tb_xbar_pipe;
  localparam int SIZE    = 32;
  localparam int DWIDTH  = 16;
  localparam int LATENCY = 2;
  localparam int IDXW    = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             mode;
  logic [SIZE*DWIDTH-1:0] in_data;
  logic [SIZE*IDXW-1:0]   in_idx;
  logic [SIZE-1:0]        in_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [SIZE*DWIDTH-1:0] out_data;
  logic [SIZE-1:0]        out_mask;
  logic                   out_conflict;

  int errors = 0;
  int checks = 0;

  xbar_pipe #(.SIZE(SIZE), .DWIDTH(DWIDTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .in_data_i(in_data), .in_idx_i(in_idx), .in_mask_i(in_mask),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_mask_o(out_mask), .out_conflict_o(out_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE*DWIDTH-1:0] rep(input int v);
    logic [SIZE*DWIDTH-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*DWIDTH +: DWIDTH] = v[DWIDTH-1:0];
    return r;
  endfunction

  task automatic send(input logic [1:0] m, input logic [SIZE*DWIDTH-1:0] d,
                      input logic [SIZE*IDXW-1:0] ix, input logic [SIZE-1:0] mk);
    int lat;
    @(negedge clk);
    mode = m; in_data = d; in_idx = ix; in_mask = mk; in_valid = 1'b1;
    #1 check("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LATENCY - 1);
  endtask

  logic [SIZE*DWIDTH-1:0] d, ed, held_data;
  logic [SIZE*IDXW-1:0]   ix;
  logic [SIZE-1:0]        em;
  int sent, recv;
  logic held_valid, acc;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mode = 2'b00;
    in_data = '1; in_idx = '0; in_mask = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_mask", out_mask, 0);
      check("rst_out_conflict", out_conflict, 0);
    end
    rst = 1'b0; in_valid = 1'b0;

    // Rotate-scatter by 1: out[j] = j-1 mod 32
    for (int i = 0; i < SIZE; i++) begin
      d[i*DWIDTH +: DWIDTH] = 16'(i);
      ix[i*IDXW +: IDXW]    = 5'd1;
      ed[i*DWIDTH +: DWIDTH] = 16'((i + 31) % 32);
    end
    send(2'b00, d, ix, '1);
    check("rot_data", out_data, ed);
    check("rot_mask", out_mask, 32'hFFFF_FFFF);
    check("rot_conflict", out_conflict, 0);

    // Rotate collision: lanes 0 (+2) and 1 (+1) both land on 2; lane 0 wins
    ix = '0;
    ix[0*IDXW +: IDXW] = 5'd2;
    ix[1*IDXW +: IDXW] = 5'd1;
    d = '0;
    d[0*DWIDTH +: DWIDTH] = 16'hAAAA;
    d[1*DWIDTH +: DWIDTH] = 16'h5555;
    ed = '0;
    ed[2*DWIDTH +: DWIDTH] = 16'hAAAA;
    send(2'b00, d, ix, 32'h0000_0003);
    check("rotcol_data", out_data, ed);
    check("rotcol_mask", out_mask, 32'h0000_0004);
    check("rotcol_conflict", out_conflict, 1);

    // Direct-scatter: lanes 3 and 7 -> 5, lane 5 -> 3, dest 7 unreached
    for (int i = 0; i < SIZE; i++) begin
      d[i*DWIDTH +: DWIDTH]  = 16'(256 + i);
      ix[i*IDXW +: IDXW]     = 5'(i);
      ed[i*DWIDTH +: DWIDTH] = 16'(256 + i);
    end
    ix[3*IDXW +: IDXW] = 5'd5;
    ix[7*IDXW +: IDXW] = 5'd5;
    ix[5*IDXW +: IDXW] = 5'd3;
    ed[3*DWIDTH +: DWIDTH] = 16'h0105;
    ed[5*DWIDTH +: DWIDTH] = 16'h0103;
    ed[7*DWIDTH +: DWIDTH] = 16'h0000;
    send(2'b01, d, ix, '1);
    check("dir_data", out_data, ed);
    check("dir_mask", out_mask, 32'hFFFF_FF7F);
    check("dir_conflict", out_conflict, 1);

    // Gather reversed with lane 31 masked off: lanes 0 and 31 drop out
    for (int j = 0; j < SIZE; j++) begin
      d[j*DWIDTH +: DWIDTH]  = 16'(512 + j);
      ix[j*IDXW +: IDXW]     = 5'(31 - j);
      ed[j*DWIDTH +: DWIDTH] = 16'(512 + 31 - j);
    end
    ed[0*DWIDTH +: DWIDTH]  = '0;
    ed[31*DWIDTH +: DWIDTH] = '0;
    send(2'b10, d, ix, 32'h7FFF_FFFF);
    check("gat_data", out_data, ed);
    check("gat_mask", out_mask, 32'h7FFF_FFFE);
    check("gat_conflict", out_conflict, 0);

    // Broadcast lane 9
    for (int i = 0; i < SIZE; i++) begin
      d[i*DWIDTH +: DWIDTH] = 16'(i);
      ix[i*IDXW +: IDXW]    = 5'(i);
    end
    ix[0*IDXW +: IDXW]    = 5'd9;
    d[9*DWIDTH +: DWIDTH] = 16'hBEEF;
    send(2'b11, d, ix, '1);
    check("bc_data", out_data, rep(16'hBEEF));
    check("bc_mask", out_mask, 32'hFFFF_FFFF);
    check("bc_conflict", out_conflict, 0);

    // All-zero mask still produces a beat
    send(2'b01, d, ix, '0);
    check("zmask_valid", out_valid, 1);
    check("zmask_data", out_data, 0);
    check("zmask_mask", out_mask, 0);

    // Backpressure stream: identity gather, out_ready pattern 1,0,0,1
    for (int i = 0; i < SIZE; i++) ix[i*IDXW +: IDXW] = 5'(i);
    @(negedge clk);
    mode = 2'b10; in_idx = ix; in_mask = '1;
    sent = 0; recv = 0; held_valid = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      if (cyc != 0) @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 20);
      in_data   = rep(sent);
      #1;
      if (held_valid) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
      end
      check("in_ready_adv", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        check("stream_order", out_data, rep(recv));
        recv++;
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    check("stream_recv", recv, 20);
    check("stream_sent", sent, 20);

    // Mid-flight reset discards the in-flight beat
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = rep(16'h1234); in_mask = '1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_mid_no_output", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
